operand_seq8: RTL and testbench

OPERAND_SEQ8 -- requirements
Module: operand_seq8

---
 rtl/operand_seq8.sv | 152 +++++++++++++++
 tb/tb_operand_seq8.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_seq8.sv
// operand_seq8: key-stepped operand sequencer for an external 8-bit adder (optional key debounce: DEBOUNCE_EN).
// Latency: key edge to load takes 3 clk (2 sync flops + edge detect); result/valid are set by the single CALC cycle after B capture.
// Backpressure: none; load pulses arriving in CALC are dropped, and a held key yields a single pulse.
module operand_seq8 #(
  parameter int DB_LEN = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       cin_sw,
  input  logic       key,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic       Cin,
  input  logic [7:0] S,
  input  logic       Cout,
  output logic [8:0] result,
  output logic       valid,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    GET_A = 2'b00,
    GET_B = 2'b01,
    CALC  = 2'b10,
    SHOW  = 2'b11
  } state_t;

  if (DB_LEN < 1) begin : g_bad_db_len
    $error("operand_seq8: DB_LEN must be at least 1");
  end

  state_t     state_q, state_d;
  logic [7:0] sw_s1, sw_s2;
  logic       cin_s1, cin_s2;
  logic       key_s1, key_s2;
  logic       key_clean, key_prev, load_pulse;
  logic       ld_a, ld_b, do_calc, do_restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      cin_s1 <= 1'b0;
      cin_s2 <= 1'b0;
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      cin_s1 <= cin_sw;
      cin_s2 <= cin_s1;
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_LEN + 1);

  logic [CNT_W-1:0] db_cnt;
  logic             key_db;

  // Pressed is only declared after DB_LEN consecutive low samples; any high sample restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      key_db <= 1'b0;
    end else if (key_s2) begin
      db_cnt <= '0;
      key_db <= 1'b1;
    end else if (db_cnt == CNT_W'(DB_LEN - 1)) begin
      key_db <= 1'b0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  assign key_clean = key_db;
`else
  assign key_clean = key_s2;
`endif

  // Edge history resets low, so a key held through reset release cannot fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_prev <= 1'b0;
    else        key_prev <= key_clean;
  end

  assign load_pulse = key_prev & ~key_clean;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= GET_A;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    do_calc    = 1'b0;
    do_restart = 1'b0;
    case (state_q)
      GET_A: if (load_pulse) begin
        ld_a    = 1'b1;
        state_d = GET_B;
      end
      GET_B: if (load_pulse) begin
        ld_b    = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        do_calc = 1'b1;
        state_d = SHOW;
      end
      SHOW: if (load_pulse) begin
        do_restart = 1'b1;
        state_d    = GET_B;
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A      <= '0;
      B      <= '0;
      Cin    <= 1'b0;
      result <= '0;
      valid  <= 1'b0;
    end else begin
      if (ld_a || do_restart) A <= sw_s2;
      if (ld_b) begin
        B   <= sw_s2;
        Cin <= cin_s2;
      end
      // Starting a new sum from SHOW keeps the old result on display.
      if (do_restart) begin
        B     <= '0;
        Cin   <= 1'b0;
        valid <= 1'b0;
      end
      if (do_calc) begin
        result <= {Cout, S};
        valid  <= 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_operand_seq8.sv
// Bench for operand_seq8: vector table, reset/held-key corner cases, and random press sequences vs a transaction model.
module tb_operand_seq8;

  localparam int DB = 8;
`ifdef DEBOUNCE_EN
  localparam int PRESS_LAT = 3 + DB;
`else
  localparam int PRESS_LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] sw = '0;
  logic       cin_sw = 1'b0;
  logic       key = 1'b1;
  logic [7:0] A, B, S;
  logic       Cin, Cout;
  logic [8:0] result;
  logic       valid;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  // external adder
  assign {Cout, S} = 9'(A) + 9'(B) + 9'(Cin);

  always #5 clk = ~clk;

  operand_seq8 #(.DB_LEN(DB)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .cin_sw(cin_sw), .key(key),
    .A(A), .B(B), .Cin(Cin), .S(S), .Cout(Cout),
    .result(result), .valid(valid), .state(state)
  );

  // transaction-level model: phase 0=GET_A 1=GET_B 3=SHOW (CALC is transient)
  int         m_phase;
  logic [7:0] m_a, m_b;
  logic       m_cin;
  logic [8:0] m_res;
  logic       m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_a = '0; m_b = '0; m_cin = 1'b0; m_res = '0; m_valid = 1'b0;
  endtask

  task automatic model_press(input logic [7:0] v, input logic c);
    case (m_phase)
      0: begin m_a = v; m_phase = 1; end
      1: begin
        m_b = v; m_cin = c;
        m_res = 9'(int'(m_a) + int'(m_b) + int'(c));
        m_valid = 1'b1; m_phase = 3;
      end
      3: begin m_a = v; m_b = '0; m_cin = 1'b0; m_valid = 1'b0; m_phase = 1; end
      default: ;
    endcase
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".A"}, 32'(A), 32'(m_a));
    chk({tag, ".B"}, 32'(B), 32'(m_b));
    chk({tag, ".Cin"}, 32'(Cin), 32'(m_cin));
    chk({tag, ".result"}, 32'(result), 32'(m_res));
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
    chk({tag, ".state"}, 32'(state), 32'(m_phase));
  endtask

  // returns #1 after the edge that loads the operand; key is left held low
  task automatic press_load(input logic [7:0] v, input logic c);
    @(negedge clk);
    sw = v; cin_sw = c; key = 1'b0;
    repeat (PRESS_LAT) @(posedge clk);
    #1;
  endtask

  task automatic release_key();
    key = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".A"}, 32'(A), 0);
    chk({tag, ".B"}, 32'(B), 0);
    chk({tag, ".Cin"}, 32'(Cin), 0);
    chk({tag, ".result"}, 32'(result), 0);
    chk({tag, ".valid"}, 32'(valid), 0);
    chk({tag, ".state"}, 32'(state), 0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h25, 8'h1A, 1'b0, 9'h03F};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 9'h100};
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 9'h080};

    // asynchronous reset, no clock edge needed
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // table: first A from GET_A, later A loads come from SHOW
    for (int i = 0; i < 6; i++) begin
      press_load(vecs[i].a, 1'b0);
      model_press(vecs[i].a, 1'b0);
      chk($sformatf("v%0d.A_load.state", i), 32'(state), 1);
      chk($sformatf("v%0d.A_load.A", i), 32'(A), 32'(vecs[i].a));
      if (i > 0) begin
        chk($sformatf("v%0d.show_restart.B", i), 32'(B), 0);
        chk($sformatf("v%0d.show_restart.valid", i), 32'(valid), 0);
        chk($sformatf("v%0d.show_restart.result_kept", i), 32'(result), 32'(vecs[i-1].exp));
      end
      release_key();
      press_load(vecs[i].b, vecs[i].cin);
      model_press(vecs[i].b, vecs[i].cin);
      chk($sformatf("v%0d.B_edge.state", i), 32'(state), 2);
      chk($sformatf("v%0d.B_edge.valid", i), 32'(valid), 0);
      chk($sformatf("v%0d.B_edge.B", i), 32'(B), 32'(vecs[i].b));
      @(posedge clk); #1;
      chk($sformatf("v%0d.calc.valid", i), 32'(valid), 1);
      chk($sformatf("v%0d.calc.state", i), 32'(state), 3);
      chk($sformatf("v%0d.calc.result", i), 32'(result), 32'(vecs[i].exp));
      release_key();
      check_model($sformatf("v%0d.settled", i));
    end

    // key held low 1000 cycles in GET_A: single pulse
    @(negedge clk); rst_n = 1'b0;
    #1 check_all_zero("reset_show");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    sw = 8'h55; key = 1'b0;
    repeat (500) @(posedge clk);
    #1 chk("hold.mid.state", 32'(state), 1);
    repeat (500) @(posedge clk);
    #1 chk("hold.end.state", 32'(state), 1);
    chk("hold.end.A", 32'(A), 32'h55);

    // reset in GET_B with key still held, then no pulse on release of reset
    @(negedge clk); rst_n = 1'b0;
    #1 check_all_zero("reset_get_b");
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("held_at_release.state", 32'(state), 0);
    release_key();
    model_reset();
    check_model("after_held_release");

    // reset during CALC discards the sum
    press_load(8'h80, 1'b0);
    release_key();
    press_load(8'h80, 1'b1);
    chk("mid_calc.state", 32'(state), 2);
    rst_n = 1'b0;
    #1 check_all_zero("reset_calc");
    @(posedge clk); #1;
    check_all_zero("reset_calc_edge");
    @(negedge clk); rst_n = 1'b1;
    release_key();
    model_reset();
    check_model("after_calc_reset");

`ifdef DEBOUNCE_EN
    // bounce of 5 low cycles is rejected; DB stable low cycles give one pulse
    @(negedge clk); key = 1'b0;
    repeat (5) @(negedge clk);
    key = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("db.bounce.state", 32'(state), 0);
    @(negedge clk); sw = 8'h3C; key = 1'b0;
    repeat (PRESS_LAT - 1) @(posedge clk);
    #1 chk("db.before.state", 32'(state), 0);
    @(posedge clk); #1;
    chk("db.after.state", 32'(state), 1);
    repeat (20) @(posedge clk);
    #1 chk("db.held.state", 32'(state), 1);
    release_key();
    model_press(8'h3C, 1'b0);
    check_model("db.settled");
`endif

    // random press sequences with random extra hold time
    for (int n = 0; n < 40; n++) begin
      logic [7:0] v;
      logic       c;
      int         extra;
      v = 8'($urandom_range(0, 255));
      c = 1'($urandom_range(0, 1));
      extra = $urandom_range(0, 15);
      press_load(v, c);
      repeat (extra) @(posedge clk);
      #1;
      model_press(v, c);
      release_key();
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
